// File: rtl/display_write_arbiter.sv
// Display write arbiter: CPU writes always win; otherwise a fill engine clears ROWS x COLS cells.
// Optional macro DISPLAY_FILL_ABORT_EN adds a fillAbort input that cancels an active fill.
module display_write_arbiter #(
  parameter int ROWS = 30,
  parameter int COLS = 80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpuWrite,
  input  logic [13:0] cpuAddress,
  input  logic [2:0]  cpuData,
  input  logic        fillStart,
  input  logic [2:0]  fillColor,
`ifdef DISPLAY_FILL_ABORT_EN
  input  logic        fillAbort,
`endif
  output logic        fillBusy,
  output logic        fillDone,
  output logic        dispWrite,
  output logic [13:0] dispAddress,
  output logic [2:0]  dispData
);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  localparam logic [6:0] LAST_ROW = 7'(ROWS - 1);
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);

  state_t      state_q, state_d;
  logic [6:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic [2:0]  color_q, color_d;
  logic        wr_q, wr_d;
  logic [13:0] addr_q, addr_d;
  logic [2:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        abort;
  logic        fill_grant;
  logic        last_col;
  logic        last_cell;

`ifdef DISPLAY_FILL_ABORT_EN
  assign abort = fillAbort;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    color_d    = color_q;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    done_d     = 1'b0;
    fill_grant = (state_q == FILL) && !cpuWrite && !abort;
    last_col   = (col_q == LAST_COL);
    last_cell  = last_col && (row_q == LAST_ROW);

    // Address/data hold their last value when nothing is granted.
    if (cpuWrite) begin
      wr_d   = 1'b1;
      addr_d = cpuAddress;
      data_d = cpuData;
    end else if (fill_grant) begin
      wr_d   = 1'b1;
      addr_d = {row_q, col_q};
      data_d = color_q;
    end

    case (state_q)
      IDLE: begin
        if (fillStart) begin
          state_d = FILL;
          row_d   = '0;
          col_d   = '0;
          color_d = fillColor;
        end
      end
      FILL: begin
        if (abort) begin
          state_d = IDLE;
        end else if (fill_grant) begin
          if (last_cell) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (last_col) begin
            col_d = '0;
            row_d = row_q + 7'd1;
          end else begin
            col_d = col_q + 7'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      color_q <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      color_q <= color_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign fillBusy    = (state_q == FILL);
  assign fillDone    = done_q;
  assign dispWrite   = wr_q;
  assign dispAddress = addr_q;
  assign dispData    = data_q;

endmodule

// File: tb/tb_display_write_arbiter.sv
// Bench for display_write_arbiter: cell-index model compared every cycle plus literal checks.
module tb_display_write_arbiter;
  localparam int ROWS  = 30;
  localparam int COLS  = 80;
  localparam int CELLS = ROWS * COLS;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpuWrite;
  logic [13:0] cpuAddress;
  logic [2:0]  cpuData;
  logic        fillStart;
  logic [2:0]  fillColor;
  logic        fillBusy;
  logic        fillDone;
  logic        dispWrite;
  logic [13:0] dispAddress;
  logic [2:0]  dispData;
`ifdef DISPLAY_FILL_ABORT_EN
  logic        fillAbort;
`endif

  always #5 clk = ~clk;

  display_write_arbiter #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk),
    .reset(reset),
    .cpuWrite(cpuWrite),
    .cpuAddress(cpuAddress),
    .cpuData(cpuData),
    .fillStart(fillStart),
    .fillColor(fillColor),
`ifdef DISPLAY_FILL_ABORT_EN
    .fillAbort(fillAbort),
`endif
    .fillBusy(fillBusy),
    .fillDone(fillDone),
    .dispWrite(dispWrite),
    .dispAddress(dispAddress),
    .dispData(dispData)
  );

  // Model: fill progress is a single cell index n; row/col derived by division.
  int          m_cyc = 0;
  bit          m_busy = 1'b0;
  int          m_n = 0;
  logic [2:0]  m_color = '0;
  logic        m_write = 1'b0;
  logic [13:0] m_addr = '0;
  logic [2:0]  m_data = '0;
  logic        m_done = 1'b0;
  int          m_fill_writes = 0;
  int          m_cpu_writes = 0;
  int          m_dones = 0;
  int          m_start_cyc = 0;
  int          m_done_cyc = 0;

  always @(posedge clk) begin
    bit was_busy;
    bit ab;
    m_cyc++;
    ab = 1'b0;
`ifdef DISPLAY_FILL_ABORT_EN
    ab = fillAbort;
`endif
    if (!reset) begin
      m_busy  = 1'b0;
      m_n     = 0;
      m_color = '0;
      m_write = 1'b0;
      m_addr  = '0;
      m_data  = '0;
      m_done  = 1'b0;
    end else begin
      was_busy = m_busy;
      m_write  = 1'b0;
      m_done   = 1'b0;
      if (cpuWrite) begin
        m_write = 1'b1;
        m_addr  = cpuAddress;
        m_data  = cpuData;
        m_cpu_writes++;
      end else if (was_busy && !ab) begin
        m_write = 1'b1;
        m_addr  = {7'(m_n / COLS), 7'(m_n % COLS)};
        m_data  = m_color;
        m_n++;
        m_fill_writes++;
        if (m_n == CELLS) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_dones++;
          m_done_cyc = m_cyc;
        end
      end
      if (was_busy && ab) m_busy = 1'b0;
      if (!was_busy && fillStart) begin
        m_busy      = 1'b1;
        m_n         = 0;
        m_color     = fillColor;
        m_start_cyc = m_cyc;
      end
    end
  end

  int          checks = 0;
  int          errors = 0;
  logic [13:0] done_addr = '0;
  logic [2:0]  done_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, m_cyc);
    end
  endtask

  // Advance one cycle and compare every output with the model.
  task automatic step();
    @(negedge clk);
    check("dispWrite", 32'(dispWrite), 32'(m_write));
    check("dispAddress", 32'(dispAddress), 32'(m_addr));
    check("dispData", 32'(dispData), 32'(m_data));
    check("fillBusy", 32'(fillBusy), 32'(m_busy));
    check("fillDone", 32'(fillDone), 32'(m_done));
    if (fillDone === 1'b1) begin
      done_addr = dispAddress;
      done_data = dispData;
    end
  endtask

  task automatic idle_inputs();
    cpuWrite  = 1'b0;
    fillStart = 1'b0;
`ifdef DISPLAY_FILL_ABORT_EN
    fillAbort = 1'b0;
`endif
  endtask

  task automatic start_fill(input logic [2:0] color);
    fillStart = 1'b1;
    fillColor = color;
    step();
    fillStart = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int snap;
    int k;
    snap = m_dones;
    k = 0;
    while (m_dones == snap && k < budget) begin
      step();
      k++;
    end
    if (m_dones == snap) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual=no fillDone expected=fillDone within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_fill_writes(input int target, input int snap, input string name);
    int k;
    k = 0;
    while (m_fill_writes - snap < target && k < 500) begin
      step();
      k++;
    end
    if (m_fill_writes - snap < target) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual=%0d expected=%0d fill writes", name, m_fill_writes - snap, target);
    end
  endtask

  initial begin
    int sw, sd, sc;
    reset      = 1'b0;
    cpuWrite   = 1'b1;
    cpuAddress = 14'h1234;
    cpuData    = 3'b111;
    fillStart  = 1'b1;
    fillColor  = 3'b110;
`ifdef DISPLAY_FILL_ABORT_EN
    fillAbort  = 1'b0;
`endif

    // Reset overrides CPU write and fill start.
    for (int i = 0; i < 3; i++) step();
    check("rst_dispWrite", 32'(dispWrite), 32'd0);
    check("rst_dispAddress", 32'(dispAddress), 32'd0);
    check("rst_dispData", 32'(dispData), 32'd0);
    check("rst_fillBusy", 32'(fillBusy), 32'd0);
    check("rst_fillDone", 32'(fillDone), 32'd0);
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < 3; i++) step();

    // Full uninterrupted fill.
    sw = m_fill_writes; sd = m_dones;
    start_fill(3'b101);
    wait_done(3000, "full_fill");
    check("full_writes", 32'(m_fill_writes - sw), 32'd2400);
    check("full_dones", 32'(m_dones - sd), 32'd1);
    check("full_latency", 32'(m_done_cyc - m_start_cyc), 32'd2400);
    check("full_done_addr", 32'(done_addr), 32'({7'd29, 7'd79}));
    check("full_done_data", 32'(done_data), 32'b101);
    for (int i = 0; i < 5; i++) step();
    check("full_idle_busy", 32'(fillBusy), 32'd0);

    // CPU preemption plus an ignored restart request.
    sw = m_fill_writes; sd = m_dones; sc = m_cpu_writes;
    start_fill(3'b101);
    for (int i = 0; i < 40; i++) step();
    cpuAddress = 14'h0105;
    cpuData    = 3'b010;
    for (int i = 0; i < 5; i++) begin
      cpuWrite = 1'b1;
      step();
      check("cpu_write", 32'(dispWrite), 32'd1);
      check("cpu_addr", 32'(dispAddress), 32'h0105);
      check("cpu_data", 32'(dispData), 32'b010);
    end
    cpuWrite = 1'b0;
    for (int i = 0; i < 20; i++) step();
    fillStart = 1'b1;
    fillColor = 3'b111;
    step();
    fillStart = 1'b0;
    wait_done(3000, "preempt_fill");
    check("pre_writes", 32'(m_fill_writes - sw), 32'd2400);
    check("pre_cpu_writes", 32'(m_cpu_writes - sc), 32'd5);
    check("pre_dones", 32'(m_dones - sd), 32'd1);
    check("pre_latency", 32'(m_done_cyc - m_start_cyc), 32'd2405);
    check("pre_done_data", 32'(done_data), 32'b101);
    for (int i = 0; i < 5; i++) step();

    // Reset mid-fill abandons the fill silently.
    sw = m_fill_writes; sd = m_dones;
    start_fill(3'b011);
    wait_fill_writes(100, sw, "rst_mid_wait");
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("rstmid_busy", 32'(fillBusy), 32'd0);
    for (int i = 0; i < 50; i++) step();
    check("rstmid_writes", 32'(m_fill_writes - sw), 32'd100);
    check("rstmid_dones", 32'(m_dones - sd), 32'd0);

`ifdef DISPLAY_FILL_ABORT_EN
    // Abort with a coincident CPU write.
    sw = m_fill_writes; sd = m_dones;
    start_fill(3'b101);
    wait_fill_writes(10, sw, "abort_wait");
    fillAbort  = 1'b1;
    cpuWrite   = 1'b1;
    cpuAddress = 14'h0203;
    cpuData    = 3'b011;
    step();
    idle_inputs();
    check("abort_busy", 32'(fillBusy), 32'd0);
    check("abort_cpu_write", 32'(dispWrite), 32'd1);
    check("abort_cpu_addr", 32'(dispAddress), 32'h0203);
    for (int i = 0; i < 30; i++) step();
    check("abort_writes", 32'(m_fill_writes - sw), 32'd10);
    check("abort_dones", 32'(m_dones - sd), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/display_write_arbiter.md
DISPLAY_WRITE_ARBITER -- requirements
Module: display_write_arbiter

Interface
REQ-001 SHALL have parameter ROWS, default 30, number of character rows cleared by a fill (1..128).
REQ-002 SHALL have parameter COLS, default 80, number of character columns cleared by a fill (1..128).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port cpuWrite  input  1  CPU display write request, one cycle per write.
REQ-006 SHALL have port cpuAddress  input  14  CPU write address: row in [13:7], column in [6:0].
REQ-007 SHALL have port cpuData  input  3  CPU write data, RGB.
REQ-008 SHALL have port fillStart  input  1  one-cycle request to start a rectangle fill.
REQ-009 SHALL have port fillColor  input  3  fill data, sampled with fillStart.
REQ-010 SHALL have port fillBusy  output  1  high while the fill engine is active.
REQ-011 SHALL have port fillDone  output  1  one-cycle pulse at fill completion.
REQ-012 SHALL have port dispWrite  output  1  display memory write strobe.
REQ-013 SHALL have port dispAddress  output  14  display memory write address, same encoding as cpuAddress.
REQ-014 SHALL have port dispData  output  3  display memory write data.

Function
REQ-015 All outputs SHALL be registered; a write granted in cycle t appears on dispWrite/dispAddress/dispData in cycle t+1.
REQ-016 The fill engine SHALL have two states, IDLE and FILL; fillBusy SHALL equal (state == FILL).
REQ-017 In IDLE, fillStart=1 SHALL latch fillColor, clear the row and column counters to 0 and enter FILL next cycle.
REQ-018 fillStart while in FILL SHALL be ignored; the latched color and the counters SHALL be unchanged.
REQ-019 CPU writes SHALL have absolute priority: cpuWrite=1 SHALL be granted in the same cycle, never dropped, never delayed.
REQ-020 In FILL, in a cycle with cpuWrite=0, the engine SHALL be granted and issue a write of the latched color to {row, col}.
REQ-021 In FILL, in a cycle with cpuWrite=1, the fill counters SHALL hold.
REQ-022 After each granted fill write: col SHALL increment; at col == COLS-1, col SHALL wrap to 0 and row SHALL increment.
REQ-023 The grant of cell {ROWS-1, COLS-1} SHALL return the state to IDLE; fillDone SHALL pulse in the cycle that write appears on the outputs.
REQ-024 Without CPU interference, first fill write SHALL appear at t+2 and last at t+1+ROWS*COLS, for fillStart sampled at cycle t.
REQ-025 dispWrite SHALL be 0 in cycles where nothing is granted; dispAddress/dispData SHALL hold their previous values then.
REQ-026 Counters SHALL be 7 bits each, zero-extended into the address fields; addresses outside ROWS x COLS SHALL never be generated by the fill.

Reset
REQ-027 reset=0 at a rising edge SHALL force IDLE, counters 0, latched color 0, dispWrite=0, dispAddress=0, dispData=0, fillBusy=0, fillDone=0, overriding every other input.
REQ-028 Reset asserted mid-fill SHALL abandon the fill without a fillDone pulse; remaining cells stay unwritten.

Configuration
REQ-029 With macro DISPLAY_FILL_ABORT_EN defined, the block SHALL add input fillAbort (1 bit); fillAbort=1 in FILL SHALL return to IDLE next cycle, issue no further fill writes and pulse no fillDone; a CPU write in the same cycle SHALL still be granted.
REQ-030 Without DISPLAY_FILL_ABORT_EN, port fillAbort SHALL not exist and a started fill SHALL always run to completion or reset.

Verification
REQ-031 Reset: hold reset=0 with cpuWrite=1, fillStart=1 for 3 cycles -> all outputs 0, fillBusy=0.
REQ-032 Full fill: ROWS=30, COLS=80, fillStart with fillColor=3'b101, no CPU traffic -> exactly 2400 writes, addresses {0,0}..{29,79} in raster order, data 101, fillDone once, coincident with address {29,79}.
REQ-033 Preemption: during fill, cpuWrite=1 for 5 consecutive cycles at address 0x0105, data 3'b010 -> five CPU writes appear in order, fill resumes at the held cell, total fill writes still 2400.
REQ-034 Ignored restart: fillStart with fillColor=3'b111 during an active fill -> color stays 101, counters not reset, completion time unchanged.
REQ-035 Reset mid-fill: reset=0 for one cycle after 100 fill writes -> fillBusy=0 next cycle, no fillDone, no further fill writes.
REQ-036 Abort (DISPLAY_FILL_ABORT_EN defined): fillAbort=1 after 10 fill writes -> no more fill writes, fillBusy=0 next cycle, fillDone never asserted.
